udp_pkt_tx_mux: RTL and testbench
=================================

# udp_pkt_tx_mux

Transmit-side counterpart of the UDP receive router. Arbitrates round-robin among P_NUM_PORTS per-port payload queues and buffers one complete payload. It then emits a UDP datagram (8-byte header + payload) byte-serially toward the IPv4 packet builder. Source/destination port numbers are fixed per input by parameter; checksum is transmitted as 0x0000 (permitted for UDP over IPv4).

## Interface

- P_NUM_PORTS, 2, number of payload input queues
- P_SRC_PORTS, {16'd50000, 16'd60000}, [0:P_NUM_PORTS-1][15:0] UDP source port inserted for input i
- P_DEST_PORTS, {16'd50000, 16'd60000}, [0:P_NUM_PORTS-1][15:0] UDP destination port inserted for input i
- SIM_MODE, 0, passed to the payload FIFO
- i_txmac_clk  in  1  sole clock
- i_txmac_arst  in  1  reset, asynchronous, active-high
- i_port_byte  in  [0:P_NUM_PORTS-1][7:0]  payload byte from queue i (FWFT)
- i_port_byte_vld  in  [0:P_NUM_PORTS-1]  i_port_byte[i] valid
- i_port_last_byte  in  [0:P_NUM_PORTS-1]  marks final payload byte
- o_port_byte_rd  out  [0:P_NUM_PORTS-1]  consume current byte of queue i
- o_udp_pkt_byte  out  8  datagram byte
- o_udp_pkt_byte_vld  out  1  o_udp_pkt_byte valid
- o_udp_pkt_last_byte  out  1  final datagram byte
- i_udp_pkt_byte_rd  in  1  downstream consumes current byte
- o_udp_pkt_len  out  16  UDP length field (8 + payload bytes), stable from first header byte until last byte consumed
- o_payload_too_long  out  1  one-cycle pulse when a payload exceeds UDP_PAYLOAD_MAX_BYTES and is dropped

## Operation

- Transfer rule (both sides): a byte moves when vld & rd are high in the same cycle. rd may be high without vld.
- FSM states: IDLE, LOAD, DROP, FLUSH, HDR, PAYLOAD.
- IDLE: if any i_port_byte_vld, grant the first requester at or after rr_ptr (cyclic), latch grant, go LOAD. rr_ptr <= grant+1 mod P_NUM_PORTS.
- LOAD: o_port_byte_rd[grant]=1 (combinational from state), others 0. Each transfer writes {last, byte} into the FIFO and increments pay_cnt (16-bit).
  - Transfer with last: go HDR; o_udp_pkt_len <= pay_cnt+1+8.
  - Transfer that makes pay_cnt == UDP_PAYLOAD_MAX_BYTES without last: write that byte with last flag forced 1, pulse o_payload_too_long, go DROP.
- DROP: keep reading the granted queue, discard bytes; on transfer with last go FLUSH.
- FLUSH: read the FIFO internally, no output valid; on reading an entry with last flag go IDLE.
- HDR: hdr_idx 0..7 emits src MSB, src LSB, dst MSB, dst LSB, len MSB, len LSB, 0x00, 0x00; vld=1. hdr_idx advances only on transfer; after idx 7 transfers, go PAYLOAD.
- PAYLOAD: o_udp_pkt_byte/last from FIFO head; vld = FIFO rdata_vld; FIFO rden = i_udp_pkt_byte_rd. Transfer with last: go IDLE.
- o_udp_pkt_last_byte is never asserted in HDR; a payload is always ≥1 byte.
- Width rules: pay_cnt and o_udp_pkt_len are 16-bit unsigned. UDP_PAYLOAD_MAX_BYTES+8 < 2^16, so no wrap.

## Timing

- Reset: all outputs 0, o_udp_pkt_len 0, state IDLE, rr_ptr 0, pay_cnt 0, hdr_idx 0, FIFO emptied. Reset mid-datagram truncates silently. Upstream queues are not rewound.
- Grant latency: 1 cycle (IDLE → LOAD). rd asserts in the cycle after vld is first seen.
- With continuous input vld, an N-byte payload loads in N cycles. The first header byte is valid the cycle after the last payload byte transfers.
- Header: 8 cycles minimum. FIFO is FWFT, so the first payload byte is valid the cycle after header byte 7 transfers (no bubble).
- Back-to-back datagrams: at least 2 idle cycles on the output (IDLE + LOAD of next).
- Simultaneous requests: round-robin only. A port cannot win twice in a row while another requests.
- o_payload_too_long is asserted the cycle after the offending transfer, for exactly one cycle.

## Structure

- ethernet_support_pkg: UDP_PAYLOAD_MAX_BYTES (existing), new UDP_HDR_BYTES = 8.
- Payload buffer: one pmi_fifo_sc_fwft_v1_0, WIDTH 9, DEPTH 2**$clog2(UDP_PAYLOAD_MAX_BYTES), RESET_MODE "async". It never fills, because LOAD starts only with the FIFO empty.
- Arbiter is inline logic; no further sub-modules.

## Test plan

- Single 1-byte payload 0xAB on port 0 (src/dst 50000=0xC350), rd held high → C3 50 C3 50 00 09 00 00 AB, last on AB, o_udp_pkt_len=9.
- Ports 0 and 1 both valid from reset with 4-byte payloads each → port 0 datagram then port 1. Repeat, and rr alternates 1,0 only if port 1 is first requester after rr_ptr.
- Downstream rd toggled 1-0 every cycle over a 100-byte payload → every byte appears exactly once, in order, with len=108 and no duplicates.
- Payload of UDP_PAYLOAD_MAX_BYTES+5 bytes on port 1 → one o_payload_too_long pulse, no output vld. The next 3-byte payload on port 0 then emits correctly.
- Exactly UDP_PAYLOAD_MAX_BYTES payload → transmitted intact, no error pulse, len = max+8.
- Assert i_txmac_arst during header byte 3 → all outputs 0 within the same cycle. After release, a new 2-byte payload emits a clean 10-byte datagram.

Source files
------------

// File: rtl/udp_pkt_tx_mux_pkg.sv
// Shared constants for the UDP transmit mux: payload limits, header size and FSM encodings.
package udp_pkt_tx_mux_pkg;

  localparam int UDP_PAYLOAD_MAX_BYTES = 1472;
  localparam int UDP_HDR_BYTES         = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_DROP    = 3'd2;
  localparam logic [2:0] ST_FLUSH   = 3'd3;
  localparam logic [2:0] ST_HDR     = 3'd4;
  localparam logic [2:0] ST_PAYLOAD = 3'd5;

endpackage

// File: rtl/udp_pkt_tx_mux_fifo.sv
// Single-clock first-word-fall-through FIFO holding one buffered payload as {last, byte} entries.
module udp_pkt_tx_mux_fifo #(
  parameter int WIDTH    = 9,
  parameter int DEPTH    = 2048,
  parameter int SIM_MODE = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wren,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rden,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_rdata_vld
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic             w_empty;
  logic             w_full;

  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_full  = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);

  always_ff @(posedge i_clk) begin
    if (i_wren && !w_full) begin
      r_mem[r_wrPtr[AW-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (i_wren && !w_full) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (i_rden && !w_empty) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
    end
  end

  // In simulation builds the head reads as zero while empty, hiding stale RAM contents.
  assign o_rdata     = ((SIM_MODE != 0) && w_empty) ? '0 : r_mem[r_rdPtr[AW-1:0]];
  assign o_rdata_vld = !w_empty;

endmodule

// File: rtl/udp_pkt_tx_mux.sv
// Round-robin UDP transmit mux: buffers one payload from the granted queue, then emits header + payload.
module udp_pkt_tx_mux
  import udp_pkt_tx_mux_pkg::*;
#(
  parameter int                           P_NUM_PORTS  = 2,
  parameter logic [0:P_NUM_PORTS-1][15:0] P_SRC_PORTS  = {16'd50000, 16'd60000},
  parameter logic [0:P_NUM_PORTS-1][15:0] P_DEST_PORTS = {16'd50000, 16'd60000},
  parameter int                           SIM_MODE     = 0
) (
  input  logic                         i_txmac_clk,
  input  logic                         i_txmac_arst,
  input  logic [0:P_NUM_PORTS-1][7:0]  i_port_byte,
  input  logic [0:P_NUM_PORTS-1]       i_port_byte_vld,
  input  logic [0:P_NUM_PORTS-1]       i_port_last_byte,
  output logic [0:P_NUM_PORTS-1]       o_port_byte_rd,
  output logic [7:0]                   o_udp_pkt_byte,
  output logic                         o_udp_pkt_byte_vld,
  output logic                         o_udp_pkt_last_byte,
  input  logic                         i_udp_pkt_byte_rd,
  output logic [15:0]                  o_udp_pkt_len,
  output logic                         o_payload_too_long
);

  localparam int          W_IDX      = (P_NUM_PORTS > 1) ? $clog2(P_NUM_PORTS) : 1;
  localparam int          FIFO_DEPTH = 2 ** $clog2(UDP_PAYLOAD_MAX_BYTES);
  localparam logic [15:0] MAX_BYTES  = 16'(UDP_PAYLOAD_MAX_BYTES);
  localparam logic [15:0] HDR_BYTES  = 16'(UDP_HDR_BYTES);
  localparam logic [2:0]  HDR_LAST   = 3'(UDP_HDR_BYTES - 1);

  logic [2:0]       r_state;
  logic [W_IDX-1:0] r_grant;
  logic [W_IDX-1:0] r_rrPtr;
  logic [15:0]      r_payCnt;
  logic [2:0]       r_hdrIdx;
  logic [15:0]      r_udpLen;
  logic             r_tooLong;

  logic             w_reqFound;
  logic [W_IDX-1:0] w_reqIdx;
  logic             w_reading;
  logic             w_inVld;
  logic [7:0]       w_inByte;
  logic             w_inLast;
  logic [15:0]      w_payCntNext;
  logic             w_hitMax;
  logic             w_fifoWren;
  logic             w_fifoRden;
  logic [8:0]       w_fifoRdata;
  logic             w_fifoVld;
  logic [15:0]      w_srcPort;
  logic [15:0]      w_dstPort;
  logic [7:0]       w_hdrByte;

  // Scan cyclically from the round-robin pointer; the first valid queue wins.
  always_comb begin
    int idx;
    idx        = 0;
    w_reqFound = 1'b0;
    w_reqIdx   = '0;
    for (int i = 0; i < P_NUM_PORTS; i++) begin
      idx = (int'(r_rrPtr) + i) % P_NUM_PORTS;
      if (!w_reqFound && i_port_byte_vld[idx]) begin
        w_reqFound = 1'b1;
        w_reqIdx   = W_IDX'(idx);
      end
    end
  end

  assign w_reading    = (r_state == ST_LOAD) || (r_state == ST_DROP);
  assign w_inVld      = w_reading && i_port_byte_vld[r_grant];
  assign w_inByte     = i_port_byte[r_grant];
  assign w_inLast     = i_port_last_byte[r_grant];
  assign w_payCntNext = r_payCnt + 16'd1;
  assign w_hitMax     = (w_payCntNext == MAX_BYTES);

  always_comb begin
    o_port_byte_rd = '0;
    if (w_reading) begin
      o_port_byte_rd[r_grant] = 1'b1;
    end
  end

  // A truncated payload is closed with a forced last flag so FLUSH knows where to stop.
  assign w_fifoWren = (r_state == ST_LOAD) && w_inVld;
  assign w_fifoRden = (r_state == ST_FLUSH) || ((r_state == ST_PAYLOAD) && i_udp_pkt_byte_rd);

  udp_pkt_tx_mux_fifo #(
    .WIDTH    (9),
    .DEPTH    (FIFO_DEPTH),
    .SIM_MODE (SIM_MODE)
  ) u_payloadFifo (
    .i_clk       (i_txmac_clk),
    .i_rst       (i_txmac_arst),
    .i_wren      (w_fifoWren),
    .i_wdata     ({w_inLast | w_hitMax, w_inByte}),
    .i_rden      (w_fifoRden),
    .o_rdata     (w_fifoRdata),
    .o_rdata_vld (w_fifoVld)
  );

  assign w_srcPort = P_SRC_PORTS[r_grant];
  assign w_dstPort = P_DEST_PORTS[r_grant];

  always_comb begin
    w_hdrByte = 8'h00;
    case (r_hdrIdx)
      3'd0:    w_hdrByte = w_srcPort[15:8];
      3'd1:    w_hdrByte = w_srcPort[7:0];
      3'd2:    w_hdrByte = w_dstPort[15:8];
      3'd3:    w_hdrByte = w_dstPort[7:0];
      3'd4:    w_hdrByte = r_udpLen[15:8];
      3'd5:    w_hdrByte = r_udpLen[7:0];
      default: w_hdrByte = 8'h00;
    endcase
  end

  always_comb begin
    o_udp_pkt_byte      = 8'h00;
    o_udp_pkt_byte_vld  = 1'b0;
    o_udp_pkt_last_byte = 1'b0;
    if (r_state == ST_HDR) begin
      o_udp_pkt_byte     = w_hdrByte;
      o_udp_pkt_byte_vld = 1'b1;
    end else if (r_state == ST_PAYLOAD) begin
      o_udp_pkt_byte      = w_fifoRdata[7:0];
      o_udp_pkt_byte_vld  = w_fifoVld;
      o_udp_pkt_last_byte = w_fifoVld && w_fifoRdata[8];
    end
  end

  always_ff @(posedge i_txmac_clk or posedge i_txmac_arst) begin
    if (i_txmac_arst) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_rrPtr   <= '0;
      r_payCnt  <= '0;
      r_hdrIdx  <= '0;
      r_udpLen  <= '0;
      r_tooLong <= 1'b0;
    end else begin
      r_tooLong <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_reqFound) begin
            r_grant  <= w_reqIdx;
            r_rrPtr  <= W_IDX'((int'(w_reqIdx) + 1) % P_NUM_PORTS);
            r_payCnt <= '0;
            r_state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (w_inVld) begin
            r_payCnt <= w_payCntNext;
            if (w_inLast) begin
              r_udpLen <= w_payCntNext + HDR_BYTES;
              r_hdrIdx <= '0;
              r_state  <= ST_HDR;
            end else if (w_hitMax) begin
              r_tooLong <= 1'b1;
              r_state   <= ST_DROP;
            end
          end
        end
        ST_DROP: begin
          if (w_inVld && w_inLast) begin
            r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (w_fifoVld && w_fifoRdata[8]) begin
            r_state <= ST_IDLE;
          end
        end
        ST_HDR: begin
          if (i_udp_pkt_byte_rd) begin
            if (r_hdrIdx == HDR_LAST) begin
              r_hdrIdx <= '0;
              r_state  <= ST_PAYLOAD;
            end else begin
              r_hdrIdx <= r_hdrIdx + 3'd1;
            end
          end
        end
        ST_PAYLOAD: begin
          if (i_udp_pkt_byte_rd && w_fifoVld && w_fifoRdata[8]) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_udp_pkt_len      = r_udpLen;
  assign o_payload_too_long = r_tooLong;

endmodule

// File: tb/tb_udp_pkt_tx_mux.sv
// Directed bench for udp_pkt_tx_mux: FWFT source queues, downstream sink and expected-datagram builder.
module tb_udp_pkt_tx_mux;
  import udp_pkt_tx_mux_pkg::*;

  localparam logic [15:0] SRC_PORT [2] = '{16'd50000, 16'd60000};
  localparam logic [15:0] DST_PORT [2] = '{16'd50000, 16'd60000};

  logic             clk;
  logic             arst;
  logic [0:1][7:0]  portByte;
  logic [0:1]       portVld;
  logic [0:1]       portLast;
  logic [0:1]       portRd;
  logic [7:0]       udpByte;
  logic             udpVld;
  logic             udpLast;
  logic             udpRd;
  logic [15:0]      udpLen;
  logic             tooLong;

  logic [8:0]  srcQ [2][$];
  logic [7:0]  expPay [2][$];
  logic [8:0]  rxQ [$];
  logic [15:0] lenQ [$];
  logic        rdToggle;
  int          vldCycles;
  int          tooLongCnt;
  int          tooLongAt;
  int          takenCnt [2];
  int          nChecks;
  int          nFails;

  udp_pkt_tx_mux dut (
    .i_txmac_clk         (clk),
    .i_txmac_arst        (arst),
    .i_port_byte         (portByte),
    .i_port_byte_vld     (portVld),
    .i_port_last_byte    (portLast),
    .o_port_byte_rd      (portRd),
    .o_udp_pkt_byte      (udpByte),
    .o_udp_pkt_byte_vld  (udpVld),
    .o_udp_pkt_last_byte (udpLast),
    .i_udp_pkt_byte_rd   (udpRd),
    .o_udp_pkt_len       (udpLen),
    .o_payload_too_long  (tooLong)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int port, input int n, input int base);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'(base + i);
      srcQ[port].push_back({(i == n - 1), b});
      expPay[port].push_back(b);
    end
  endtask

  // Builds the expected datagram from the port constants and queued payload, then matches it byte by byte.
  task automatic checkDatagram(input int port, input int maxCycles);
    logic [8:0]  exp [$];
    logic [15:0] len;
    int          n;
    int          waited;
    n   = expPay[port].size();
    len = 16'(n + 8);
    exp.push_back({1'b0, SRC_PORT[port][15:8]});
    exp.push_back({1'b0, SRC_PORT[port][7:0]});
    exp.push_back({1'b0, DST_PORT[port][15:8]});
    exp.push_back({1'b0, DST_PORT[port][7:0]});
    exp.push_back({1'b0, len[15:8]});
    exp.push_back({1'b0, len[7:0]});
    exp.push_back(9'h000);
    exp.push_back(9'h000);
    for (int i = 0; i < n; i++) begin
      exp.push_back({(i == n - 1), expPay[port][i]});
    end
    expPay[port].delete();
    waited = 0;
    while (lenQ.size() == 0 && waited < maxCycles) begin
      @(posedge clk);
      waited++;
    end
    if (lenQ.size() == 0) begin
      checkOutput($sformatf("p%0d timeout", port), 32'(lenQ.size()), 32'd1);
      return;
    end
    checkOutput($sformatf("p%0d len", port), 32'(lenQ.pop_front()), 32'(len));
    for (int k = 0; k < exp.size(); k++) begin
      if (rxQ.size() == 0) begin
        checkOutput($sformatf("p%0d short at byte%0d", port, k), 32'(rxQ.size()), 32'd1);
        break;
      end
      checkOutput($sformatf("p%0d byte%0d", port, k), 32'(rxQ.pop_front()), 32'(exp[k]));
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " vld"},     32'(udpVld),  32'd0);
    checkOutput({tag, " byte"},    32'(udpByte), 32'd0);
    checkOutput({tag, " last"},    32'(udpLast), 32'd0);
    checkOutput({tag, " len"},     32'(udpLen),  32'd0);
    checkOutput({tag, " portRd"},  32'(portRd),  32'd0);
    checkOutput({tag, " tooLong"}, 32'(tooLong), 32'd0);
  endtask

  // Source/sink model: inputs change on the falling edge, transfers are decided just after it.
  initial begin
    logic [8:0] head;
    logic [1:0] take;
    portByte = '0;
    portVld  = '0;
    portLast = '0;
    udpRd    = 1'b1;
    forever begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (srcQ[p].size() > 0) begin
          head        = srcQ[p][0];
          portVld[p]  = 1'b1;
          portByte[p] = head[7:0];
          portLast[p] = head[8];
        end else begin
          portVld[p]  = 1'b0;
          portByte[p] = 8'h00;
          portLast[p] = 1'b0;
        end
      end
      udpRd = rdToggle ? ~udpRd : 1'b1;
      #1;
      for (int p = 0; p < 2; p++) begin
        take[p] = portVld[p] & portRd[p];
      end
      if (udpVld) vldCycles++;
      if (tooLong) begin
        tooLongCnt++;
        tooLongAt = takenCnt[1];
      end
      if (udpVld && udpRd) begin
        rxQ.push_back({udpLast, udpByte});
        if (udpLast) lenQ.push_back(udpLen);
      end
      @(posedge clk);
      for (int p = 0; p < 2; p++) begin
        if (take[p]) begin
          void'(srcQ[p].pop_front());
          takenCnt[p]++;
        end
      end
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic doReset();
    arst = 1'b1;
    repeat (3) @(negedge clk);
    arst = 1'b0;
    rxQ.delete();
    lenQ.delete();
  endtask

  initial begin
    int waited;
    nChecks    = 0;
    nFails     = 0;
    rdToggle   = 1'b0;
    vldCycles  = 0;
    tooLongCnt = 0;
    tooLongAt  = 0;
    takenCnt   = '{0, 0};
    arst       = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    checkIdleOutputs("inReset");
    arst = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    checkOutput("postReset vld", 32'(udpVld), 32'd0);
    checkOutput("postReset len", 32'(udpLen), 32'd0);

    $display("[TB] single one-byte payload");
    applyStimulus(0, 1, 8'hAB);
    checkDatagram(0, 100);

    $display("[TB] simultaneous requests and round robin");
    doReset();
    applyStimulus(0, 4, 8'h10);
    applyStimulus(1, 4, 8'h20);
    checkDatagram(0, 100);
    checkDatagram(1, 100);
    applyStimulus(0, 3, 8'h30);
    checkDatagram(0, 100);
    applyStimulus(0, 4, 8'h40);
    applyStimulus(1, 4, 8'h50);
    checkDatagram(1, 100);
    checkDatagram(0, 100);

    $display("[TB] 100-byte payload with toggling downstream read");
    rdToggle = 1'b1;
    applyStimulus(0, 100, 8'h00);
    checkDatagram(0, 1000);
    rdToggle = 1'b0;

    $display("[TB] oversize payload is dropped");
    vldCycles  = 0;
    tooLongCnt = 0;
    takenCnt   = '{0, 0};
    applyStimulus(1, UDP_PAYLOAD_MAX_BYTES + 5, 8'h01);
    expPay[1].delete();
    waited = 0;
    while (srcQ[1].size() != 0 && waited < 4 * UDP_PAYLOAD_MAX_BYTES) begin
      @(posedge clk);
      waited++;
    end
    repeat (UDP_PAYLOAD_MAX_BYTES + 20) @(posedge clk);
    checkOutput("drop srcDrained", 32'(srcQ[1].size()), 32'd0);
    checkOutput("drop tooLongPulses", 32'(tooLongCnt), 32'd1);
    checkOutput("drop tooLongTiming", 32'(tooLongAt), 32'(UDP_PAYLOAD_MAX_BYTES));
    checkOutput("drop noOutputVld", 32'(vldCycles), 32'd0);
    checkOutput("drop noRxBytes", 32'(rxQ.size()), 32'd0);
    applyStimulus(0, 3, 8'hC0);
    checkDatagram(0, 200);

    $display("[TB] payload of exactly the maximum size");
    tooLongCnt = 0;
    applyStimulus(0, UDP_PAYLOAD_MAX_BYTES, 8'h07);
    checkDatagram(0, 4 * UDP_PAYLOAD_MAX_BYTES);
    checkOutput("max noTooLong", 32'(tooLongCnt), 32'd0);

    $display("[TB] reset during header byte 3");
    applyStimulus(1, 2, 8'h5A);
    expPay[1].delete();
    waited = 0;
    while (rxQ.size() != 3 && waited < 200) begin
      @(posedge clk);
      #2;
      waited++;
    end
    checkOutput("midReset reachedHdr3", 32'(rxQ.size()), 32'd3);
    arst = 1'b1;
    #1;
    checkIdleOutputs("midReset");
    repeat (2) @(negedge clk);
    arst = 1'b0;
    rxQ.delete();
    lenQ.delete();
    applyStimulus(0, 2, 8'h77);
    checkDatagram(0, 200);
    repeat (10) @(posedge clk);
    checkOutput("afterReset rxClean", 32'(rxQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
